// File: rtl/chroma_pkg.sv
// Shared chroma-control constants, used by both the chroma controller and the keying mixer.
package chroma_pkg;
    localparam int PIX_W_DEF = 8;
    localparam int COL_W_DEF = 3;

    localparam logic [7:0] TON_RST     = 8'hA4;
    localparam logic [2:0] COLOR_L_RST = 3'b000;
    localparam logic [2:0] COLOR_P_RST = 3'b111;
endpackage

// File: rtl/chroma_key_mixer_if.sv
// Pixel stream into and out of the chroma keyer: luma beats in, keyed RGB beats out.
interface chroma_key_mixer_if #(
    parameter int PIX_W = 8,
    parameter int COL_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic [PIX_W-1:0] in_luma;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_fg;
    logic [COL_W-1:0] out_rgb;

    modport master (
        output in_valid, in_sof, in_luma, out_ready,
        input  in_ready, out_valid, out_sof, out_fg, out_rgb
    );

    modport slave (
        input  in_valid, in_sof, in_luma, out_ready,
        output in_ready, out_valid, out_sof, out_fg, out_rgb
    );
endinterface

// File: rtl/chroma_cfg_shadow.sv
// Frame-start shadow of threshold/colours; the loading beat sees the new values via bypass.
module chroma_cfg_shadow
    import chroma_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int COL_W = COL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PIX_W-1:0] ton,
    input  logic [COL_W-1:0] color_l,
    input  logic [COL_W-1:0] color_p,
    output logic [PIX_W-1:0] eff_ton,
    output logic [COL_W-1:0] eff_l,
    output logic [COL_W-1:0] eff_p
);
    logic [PIX_W-1:0] sh_ton;
    logic [COL_W-1:0] sh_l;
    logic [COL_W-1:0] sh_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_ton <= PIX_W'(TON_RST);
            sh_l   <= COL_W'(COLOR_L_RST);
            sh_p   <= COL_W'(COLOR_P_RST);
        end else if (load) begin
            sh_ton <= ton;
            sh_l   <= color_l;
            sh_p   <= color_p;
        end
    end

    // sof beat must key with the settings it is loading, not the previous frame's
    assign eff_ton = load ? ton     : sh_ton;
    assign eff_l   = load ? color_l : sh_l;
    assign eff_p   = load ? color_p : sh_p;
endmodule

// File: rtl/chroma_key_mixer.sv
// Luma-threshold keyer: 2-stage pipeline with global stall, plus per-frame foreground count.
module chroma_key_mixer
    import chroma_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] ton,
    input  logic [COL_W-1:0] color_l,
    input  logic [COL_W-1:0] color_p,
    chroma_key_mixer_if.slave pix,
    output logic [CNT_W-1:0] fg_count,
    output logic             cnt_valid
);
    typedef struct packed {
        logic             sof;
        logic             fg;
        logic [COL_W-1:0] rgb;
    } pix_t;

    localparam int STAGES = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PIX_W-1:0] eff_ton;
    logic [COL_W-1:0] eff_l;
    logic [COL_W-1:0] eff_p;
    logic             adv;
    logic             acc;
    logic [STAGES:1]  vld_pipe;
    pix_t             s1_d;
    pix_t             s1_q;
    pix_t             s2_q;
    logic [CNT_W-1:0] run_cnt;

    // Single advance for the whole pipe: a stalled output freezes both stages
    assign adv          = !vld_pipe[STAGES] || pix.out_ready;
    assign acc          = pix.in_valid && adv;
    assign pix.in_ready = adv;

    assign pix.out_valid = vld_pipe[STAGES];
    assign pix.out_sof   = s2_q.sof;
    assign pix.out_fg    = s2_q.fg;
    assign pix.out_rgb   = s2_q.rgb;

    chroma_cfg_shadow #(
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .load    (acc && pix.in_sof),
        .ton     (ton),
        .color_l (color_l),
        .color_p (color_p),
        .eff_ton (eff_ton),
        .eff_l   (eff_l),
        .eff_p   (eff_p)
    );

    always_comb begin
        s1_d.sof = pix.in_sof;
        s1_d.fg  = (pix.in_luma >= eff_ton);
        s1_d.rgb = s1_d.fg ? eff_l : eff_p;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            run_cnt   <= '0;
            fg_count  <= '0;
            cnt_valid <= 1'b0;
        end else begin
            cnt_valid <= 1'b0;
            if (adv) begin
                vld_pipe <= {vld_pipe[STAGES-1:1], pix.in_valid};
                if (vld_pipe[STAGES-1])
                    s2_q <= s1_q;
            end
            if (acc) begin
                s1_q <= s1_d;
                // Count is taken at accept time so a stalled output never delays publishing
                if (pix.in_sof) begin
                    fg_count  <= run_cnt;
                    cnt_valid <= 1'b1;
                    run_cnt   <= CNT_W'(s1_d.fg);
                end else if (s1_d.fg && run_cnt != CNT_MAX) begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end
        end
    end
endmodule
